// File: rtl/wb_servo_multi.sv
// Multi-channel Wishbone servo/PWM controller. Bus writes land in shadow registers;
// each channel copies them into its active set only at its own period boundary.
module wb_servo_multi #(
    parameter int NCH    = 4,
    parameter int PER_W  = 23,
    parameter int DUTY_W = 18
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wb_stb_i,
    input  logic            wb_cyc_i,
    output logic            wb_ack_o,
    input  logic            wb_we_i,
    input  logic [31:0]     wb_adr_i,
    input  logic [3:0]      wb_sel_i,
    input  logic [31:0]     wb_dat_i,
    output logic [31:0]     wb_dat_o,
    output logic [NCH-1:0]  servo_o,
    output logic            irq_o
);

    logic              ack_q, ack_d;
    logic [31:0]       dat_q, dat_d;
    logic [NCH-1:0]    ctrl_q, ctrl_d;
    logic [NCH-1:0]    status_q, status_d;
    logic [NCH-1:0]    irqen_q, irqen_d;
    logic [NCH-1:0]    servo_q, servo_d;
    logic [PER_W-1:0]  per_sh_q [NCH];
    logic [PER_W-1:0]  per_sh_d [NCH];
    logic [DUTY_W-1:0] duty_sh_q [NCH];
    logic [DUTY_W-1:0] duty_sh_d [NCH];
    logic [PER_W-1:0]  per_a_q [NCH];
    logic [PER_W-1:0]  per_a_d [NCH];
    logic [DUTY_W-1:0] duty_a_q [NCH];
    logic [DUTY_W-1:0] duty_a_d [NCH];
    logic [PER_W-1:0]  cnt_q [NCH];
    logic [PER_W-1:0]  cnt_d [NCH];

    logic              access_s;
    logic              req_s;
    logic              wr_s;
    logic [4:0]        idx_s;
    logic [31:0]       rdata_s;
    logic [NCH-1:0]    w1c_s;
    logic [NCH-1:0]    done_s;
    logic [NCH-1:0]    per_we_s;
    logic [NCH-1:0]    duty_we_s;
    logic              unused_bits_s;

    // Byte lanes, upper address bits and data bits beyond the register widths carry no meaning here.
    assign unused_bits_s = &{1'b0, wb_sel_i, wb_adr_i, wb_dat_i};

    assign wb_ack_o = wb_stb_i & wb_cyc_i & ack_q;
    assign wb_dat_o = dat_q;
    assign servo_o  = servo_q;
    assign irq_o    = |(status_q & irqen_q);

    // Bus handshake, address decode and read mux
    always_comb begin
        access_s  = wb_stb_i & wb_cyc_i;
        req_s     = access_s & ~ack_q;
        wr_s      = req_s & wb_we_i;
        idx_s     = wb_adr_i[6:2];
        rdata_s   = 32'd0;
        per_we_s  = {NCH{1'b0}};
        duty_we_s = {NCH{1'b0}};
        for (int n = 0; n < NCH; n++) begin
            per_we_s[n]  = wr_s & (idx_s == 5'(4 + 2 * n));
            duty_we_s[n] = wr_s & (idx_s == 5'(5 + 2 * n));
        end
        case (idx_s)
            5'd0: rdata_s = 32'(ctrl_q);
            5'd1: rdata_s = 32'(status_q);
            5'd2: rdata_s = 32'(irqen_q);
            default: begin
                // Anything not matching a live channel (reserved, channels >= NCH) reads 0
                for (int n = 0; n < NCH; n++) begin
                    if (idx_s == 5'(4 + 2 * n)) begin
                        rdata_s = 32'(per_sh_q[n]);
                    end else if (idx_s == 5'(5 + 2 * n)) begin
                        rdata_s = 32'(duty_sh_q[n]);
                    end else begin
                        rdata_s = rdata_s;
                    end
                end
            end
        endcase
        ack_d = req_s;
        dat_d = (req_s & ~wb_we_i) ? rdata_s : 32'd0;
    end

    // Control/shadow register updates from bus writes
    always_comb begin
        ctrl_d  = (wr_s && idx_s == 5'd0) ? wb_dat_i[NCH-1:0] : ctrl_q;
        irqen_d = (wr_s && idx_s == 5'd2) ? wb_dat_i[NCH-1:0] : irqen_q;
        w1c_s   = (wr_s && idx_s == 5'd1) ? wb_dat_i[NCH-1:0] : {NCH{1'b0}};
        for (int n = 0; n < NCH; n++) begin
            per_sh_d[n]  = per_we_s[n]  ? wb_dat_i[PER_W-1:0]  : per_sh_q[n];
            duty_sh_d[n] = duty_we_s[n] ? wb_dat_i[DUTY_W-1:0] : duty_sh_q[n];
        end
    end

    // Per-channel counters, boundary reload and PWM compare
    always_comb begin
        done_s  = {NCH{1'b0}};
        servo_d = {NCH{1'b0}};
        for (int n = 0; n < NCH; n++) begin
            cnt_d[n]    = cnt_q[n];
            per_a_d[n]  = per_a_q[n];
            duty_a_d[n] = duty_a_q[n];
            if (!ctrl_q[n] || per_a_q[n] == {PER_W{1'b0}}) begin
                // Idle channel tracks the shadow so enabling starts a fresh period at once
                cnt_d[n]    = {PER_W{1'b0}};
                per_a_d[n]  = per_sh_q[n];
                duty_a_d[n] = duty_sh_q[n];
            end else begin
                servo_d[n] = (cnt_q[n] < PER_W'(duty_a_q[n]));
                if (cnt_q[n] == per_a_q[n] - PER_W'(1)) begin
                    cnt_d[n]    = {PER_W{1'b0}};
                    per_a_d[n]  = per_sh_q[n];
                    duty_a_d[n] = duty_sh_q[n];
                    done_s[n]   = 1'b1;
                end else begin
                    cnt_d[n] = cnt_q[n] + PER_W'(1);
                end
            end
        end
        // A period end in the same cycle as a clear keeps the flag set
        status_d = done_s | (status_q & ~w1c_s);
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_q    <= 1'b0;
            dat_q    <= 32'd0;
            ctrl_q   <= {NCH{1'b0}};
            status_q <= {NCH{1'b0}};
            irqen_q  <= {NCH{1'b0}};
            servo_q  <= {NCH{1'b0}};
            for (int n = 0; n < NCH; n++) begin
                per_sh_q[n]  <= {PER_W{1'b0}};
                duty_sh_q[n] <= {DUTY_W{1'b0}};
                per_a_q[n]   <= {PER_W{1'b0}};
                duty_a_q[n]  <= {DUTY_W{1'b0}};
                cnt_q[n]     <= {PER_W{1'b0}};
            end
        end else begin
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            ctrl_q   <= ctrl_d;
            status_q <= status_d;
            irqen_q  <= irqen_d;
            servo_q  <= servo_d;
            for (int n = 0; n < NCH; n++) begin
                per_sh_q[n]  <= per_sh_d[n];
                duty_sh_q[n] <= duty_sh_d[n];
                per_a_q[n]   <= per_a_d[n];
                duty_a_q[n]  <= duty_a_d[n];
                cnt_q[n]     <= cnt_d[n];
            end
        end
    end

endmodule

// File: tb/tb_wb_servo_multi.sv
// Directed bench for wb_servo_multi: register table plus timed PWM/IRQ/reset sequences.
module tb_wb_servo_multi;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_stb_i, wb_cyc_i, wb_we_i;
    logic        wb_ack_o;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic [3:0]  servo_o;
    logic        irq_o;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    wb_servo_multi #(.NCH(4), .PER_W(23), .DUTY_W(18)) dut (
        .clk(clk), .reset(reset),
        .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o),
        .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i),
        .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .servo_o(servo_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // One bus access; ack must arrive on the second falling edge after request
    task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                       output logic [31:0] rd);
        int lat;
        @(posedge clk); #1;
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = wd;
        lat = 0;
        rd  = 32'd0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            lat++;
            if (wb_ack_o) begin
                rd = wb_dat_o;
                break;
            end
        end
        chk($sformatf("ack_latency@%h", adr), 32'(lat), 32'd2);
        @(posedge clk); #1;
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic add(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                       input logic [31:0] exp);
        vec_t v;
        v.we = we; v.adr = adr; v.wd = wd; v.exp = exp;
        tbl.push_back(v);
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        logic        got;
        int          ph, d;

        reset = 1'b1;
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = 32'd0; wb_dat_i = 32'd0; wb_sel_i = 4'hF;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_servo", 32'(servo_o), 32'd0);
        chk("rst_irq", 32'(irq_o), 32'd0);
        chk("rst_ack", 32'(wb_ack_o), 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Register map vectors
        for (int a = 0; a < 12; a++) add(1'b0, 32'(4 * a), 32'd0, 32'd0);
        add(1'b1, 32'h50, 32'hFFFF_FFFF, 32'd0);
        add(1'b1, 32'h0C, 32'hFFFF_FFFF, 32'd0);
        add(1'b0, 32'h50, 32'd0, 32'd0);
        add(1'b0, 32'h0C, 32'd0, 32'd0);
        add(1'b0, 32'h00, 32'd0, 32'd0);
        add(1'b0, 32'h08, 32'd0, 32'd0);
        add(1'b0, 32'h10, 32'd0, 32'd0);
        add(1'b0, 32'h14, 32'd0, 32'd0);
        add(1'b1, 32'h28, 32'hFFFF_FFFF, 32'd0);
        add(1'b1, 32'h2C, 32'hFFFF_FFFF, 32'd0);
        add(1'b0, 32'h28, 32'd0, 32'h007F_FFFF);
        add(1'b0, 32'h2C, 32'd0, 32'h0003_FFFF);
        add(1'b0, 32'h20, 32'd0, 32'd0);
        add(1'b1, 32'h08, 32'h0000_00FF, 32'd0);
        add(1'b0, 32'h08, 32'd0, 32'h0000_000F);
        add(1'b1, 32'h00, 32'h0000_00F0, 32'd0);
        add(1'b0, 32'h00, 32'd0, 32'd0);
        add(1'b1, 32'h08, 32'd0, 32'd0);
        add(1'b1, 32'h28, 32'd0, 32'd0);
        add(1'b1, 32'h2C, 32'd0, 32'd0);
        add(1'b1, 32'h04, 32'h0000_000F, 32'd0);
        add(1'b0, 32'h04, 32'd0, 32'd0);
        add(1'b0, 32'h08, 32'd0, 32'd0);
        add(1'b0, 32'h28, 32'd0, 32'd0);

        foreach (tbl[i]) begin
            bus(tbl[i].we, tbl[i].adr, tbl[i].wd, rd);
            if (!tbl[i].we) begin
                chk($sformatf("tbl[%0d] rd@%h", i, tbl[i].adr), rd, tbl[i].exp);
                chk($sformatf("tbl[%0d] dat_idle", i), wb_dat_o, 32'd0);
            end
        end
        chk("servo_idle", 32'(servo_o), 32'd0);

        // Channel 0 at period 10 / duty 3; enable ack edge = P1, first high after P2
        bus(1'b1, 32'h10, 32'd10, rd);
        bus(1'b1, 32'h14, 32'd3, rd);
        bus(1'b1, 32'h00, 32'd1, rd);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            e = ((i % 10) < 3);
            chk($sformatf("pwm_10_3[%0d]", i), 32'(servo_o), 32'(e));
        end

        // DUTY_0=6 lands at cnt=1; current period stays 3 high, next one is 6 high
        bus(1'b1, 32'h14, 32'd6, rd);
        for (int j = 0; j < 18; j++) begin
            @(negedge clk);
            ph = (j + 2) % 10;
            d  = (j >= 8) ? 6 : 3;
            e  = (ph < d);
            chk($sformatf("duty_change[%0d]", j), 32'(servo_o), 32'(e));
        end

        // Interrupt: STATUS[0] already sticky, so irq asserts as soon as enabled
        bus(1'b1, 32'h08, 32'd1, rd);
        chk("irq_on_enable", 32'(irq_o), 32'd1);
        bus(1'b1, 32'h04, 32'd1, rd);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk($sformatf("irq_after_w1c[%0d]", j), 32'(irq_o), 32'(j == 4));
        end

        // W1C ack edge coincides with a period boundary: set must win
        repeat (8) @(posedge clk);
        bus(1'b1, 32'h04, 32'd1, rd);
        bus(1'b0, 32'h04, 32'd0, rd);
        chk("status_set_wins", rd, 32'd1);
        chk("irq_set_wins", 32'(irq_o), 32'd1);

        // Channel 1: duty beyond period gives constant high
        bus(1'b1, 32'h1C, 32'd20, rd);
        bus(1'b1, 32'h18, 32'd8, rd);
        bus(1'b1, 32'h00, 32'd3, rd);
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            chk($sformatf("ch1_high[%0d]", j), 32'(servo_o[1]), 32'd1);
            chk($sformatf("ch23_low[%0d]", j), 32'(servo_o[3:2]), 32'd0);
        end

        // DUTY_1=0: constant low once the running period has ended
        bus(1'b1, 32'h1C, 32'd0, rd);
        repeat (10) @(negedge clk);
        bus(1'b1, 32'h04, 32'd2, rd);
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            chk($sformatf("ch1_low[%0d]", j), 32'(servo_o[1]), 32'd0);
        end
        bus(1'b0, 32'h04, 32'd0, rd);
        chk("ch1_status_duty0", rd & 32'd2, 32'd2);

        // PERIOD_1=0: channel parks, no further STATUS[1]
        bus(1'b1, 32'h18, 32'd0, rd);
        repeat (10) @(negedge clk);
        bus(1'b1, 32'h04, 32'd2, rd);
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            chk($sformatf("ch1_per0_low[%0d]", j), 32'(servo_o[1]), 32'd0);
        end
        bus(1'b0, 32'h04, 32'd0, rd);
        chk("ch1_status_per0", rd & 32'd2, 32'd0);
        bus(1'b0, 32'h18, 32'd0, rd);
        chk("per1_readback", rd, 32'd0);
        bus(1'b0, 32'h14, 32'd0, rd);
        chk("duty0_readback", rd, 32'd6);

        // Asynchronous reset in the middle of a high pulse
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (servo_o[0]) begin
                got = 1'b1;
                break;
            end
        end
        chk("pulse_seen_before_reset", 32'(got), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_servo", 32'(servo_o), 32'd0);
        chk("async_rst_irq", 32'(irq_o), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus(1'b0, 32'h10, 32'd0, rd);
        chk("per0_after_reset", rd, 32'd0);
        bus(1'b0, 32'h00, 32'd0, rd);
        chk("ctrl_after_reset", rd, 32'd0);

        // Reset while ack is high drops it immediately
        bus(1'b1, 32'h10, 32'd5, rd);
        @(posedge clk); #1;
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h10;
        @(negedge clk);
        @(negedge clk);
        chk("midacc_ack", 32'(wb_ack_o), 32'd1);
        chk("midacc_dat", wb_dat_o, 32'd5);
        #1 reset = 1'b1;
        #1;
        chk("midacc_ack_dropped", 32'(wb_ack_o), 32'd0);
        chk("midacc_dat_cleared", wb_dat_o, 32'd0);
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        bus(1'b0, 32'h10, 32'd0, rd);
        chk("per0_after_midacc_reset", rd, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
